// File: rtl/bram_arb_pkg.sv
// Shared types and default sizing for the block-RAM port arbiter.
// Also holds the round-robin pointer wrap helper used by the arbiter.
package bram_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_DATA_W  = 16;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } arb_state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request vector plus rotating pointer gives a one-hot grant,
// the winner index and the pointer value that follows this grant.
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic [IDX_W-1:0] o_next_ptr
);

  localparam int POS_W = IDX_W + 1;

  logic [N-1:0]     w_mask;
  logic [2*N-1:0]   w_dbl;
  logic [POS_W-1:0] w_pos;

  // Low copy keeps only requesters at or past the pointer; high copy supplies the wrap-around.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (IDX_W'(i) >= i_ptr);
    end
    w_dbl = {i_req, i_req & w_mask};
  end

  // Lowest set bit of the doubled vector, scanning downward so the lowest hit wins.
  always_comb begin
    w_pos = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      w_pos = w_dbl[i] ? POS_W'(i) : w_pos;
    end
  end

  // Fold the doubled position back onto a requester index and form the grant.
  always_comb begin
    o_any = |i_req;
    if (w_pos >= POS_W'(N)) begin
      o_idx = IDX_W'(w_pos - POS_W'(N));
    end else begin
      o_idx = IDX_W'(w_pos);
    end
    if (o_any) begin
      o_grant = N'(1) << o_idx;
    end else begin
      o_grant = '0;
    end
    o_next_ptr = IDX_W'(wrap_inc(32'(o_idx), 32'(N)));
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block RAM between NUM_REQ requesters with round-robin
// arbitration, routes read data back to the issuer and zero-fills the RAM on demand.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_req,
  output logic                      clr_busy,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic                      ram_rst,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_di,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int                IDX_W     = $clog2(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  arb_state_e          r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0]  r_rsp_valid;

  logic [NUM_REQ-1:0]  w_arb_req;
  logic                w_any;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_next_ptr;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  // Requests only compete while arbitrating and out of reset.
  always_comb begin
    if (rst_n && (r_state == ST_ARB)) begin
      w_arb_req = req_valid;
    end else begin
      w_arb_req = '0;
    end
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req      (w_arb_req),
    .i_ptr      (r_rr_ptr),
    .o_any      (w_any),
    .o_grant    (w_grant),
    .o_idx      (w_idx),
    .o_next_ptr (w_next_ptr)
  );

  assign w_sel_we   = req_we[w_idx];
  assign w_sel_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_data = req_wdata[int'(w_idx)*DATA_W +: DATA_W];

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = ram_dout;

  // RAM port and handshake drive; ram_rst follows ram_we so a write never leaves dout stale.
  always_comb begin
    req_ready = '0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_rst   = 1'b0;
    ram_addr  = '0;
    ram_di    = '0;
    clr_busy  = 1'b0;
    if (!rst_n) begin
      clr_busy = 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_rst  = 1'b1;
          ram_addr = r_clr_cnt;
          ram_di   = '0;
          clr_busy = 1'b1;
        end
        ST_ARB: begin
          if (w_any) begin
            req_ready = w_grant;
            ram_en    = 1'b1;
            ram_we    = w_sel_we;
            ram_rst   = w_sel_we;
            ram_addr  = w_sel_addr;
            ram_di    = w_sel_data;
          end else begin
            req_ready = '0;
          end
        end
        default: begin
          clr_busy = 1'b0;
        end
      endcase
    end
  end

  // State, clear counter, round-robin pointer and the one-cycle read-response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        r_state <= ST_CLEAR;
      end else begin
        r_state <= ST_ARB;
      end
      r_clr_cnt   <= '0;
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rsp_valid <= '0;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= ST_ARB;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        ST_ARB: begin
          if (clr_req) begin
            r_state <= ST_CLEAR;
          end
          if (w_any) begin
            r_rr_ptr <= w_next_ptr;
          end
          if (w_any && !w_sel_we) begin
            r_rsp_valid <= w_grant;
          end else begin
            r_rsp_valid <= '0;
          end
        end
        default: begin
          r_state     <= ST_ARB;
          r_clr_cnt   <= '0;
          r_rsp_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: behavioural RAM, cycle-level reference model of arbitration/clear,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bram_port_arbiter;

  localparam int NR    = 4;
  localparam int AW    = 10;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr_req = 1'b0;
  logic              clr_busy;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_we = '0;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              ram_en, ram_we, ram_rst;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_di;
  logic [DW-1:0]     ram_dout = '0;

  logic [AW-1:0]     a_addr [NR];
  logic [DW-1:0]     a_data [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_addr[g*AW +: AW]  = a_addr[g];
    assign req_wdata[g*DW +: DW] = a_data[g];
  end

  bram_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_rst(ram_rst),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural single-port RAM with registered, resettable output.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rst) ram_dout <= '0;
      else         ram_dout <= ram_mem[ram_addr];
      if (ram_we)  ram_mem[ram_addr] <= ram_di;
    end
  end

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_clear = 1;
  int            m_cnt = 0;
  int            m_ptr = 0;
  logic [NR-1:0] m_rsp = '0;
  logic [DW-1:0] m_rsp_data = '0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = DW'(i * 37 + 5);
      m_mem[i]   = DW'(i * 37 + 5);
    end
    for (int i = 0; i < NR; i++) begin
      a_addr[i] = '0;
      a_data[i] = '0;
    end
  end

  // Compare process: predicts this cycle's outputs from the rules and checks them.
  always @(negedge clk) begin : model
    logic [NR-1:0] e_ready, e_rsp;
    logic          e_en, e_we, e_rst, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_di, e_data;
    int            w;
    e_ready = '0; e_rsp = '0; e_en = 1'b0; e_we = 1'b0; e_rst = 1'b0; e_busy = 1'b0;
    e_addr = '0; e_di = '0; e_data = '0; w = -1;
    if (!rst_n) begin
      m_clear = 1; m_cnt = 0; m_ptr = 0; m_rsp = '0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_ram_en", 32'(ram_en), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_rst", 32'(ram_rst), 32'd0);
      chk("rst_clr_busy", 32'(clr_busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end else begin
      e_rsp = m_rsp; e_data = m_rsp_data; m_rsp = '0;
      if (m_clear != 0) begin
        e_en = 1'b1; e_we = 1'b1; e_rst = 1'b1; e_busy = 1'b1;
        e_addr = AW'(m_cnt); e_di = '0;
        m_mem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin m_clear = 0; m_cnt = 0; end
        else m_cnt++;
      end else begin
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        if (w >= 0) begin
          e_ready[w] = 1'b1; e_en = 1'b1; e_we = req_we[w]; e_rst = req_we[w];
          e_addr = a_addr[w]; e_di = a_data[w];
          if (req_we[w]) m_mem[a_addr[w]] = a_data[w];
          else begin m_rsp[w] = 1'b1; m_rsp_data = m_mem[a_addr[w]]; end
          m_ptr = (w + 1) % NR;
        end
        if (clr_req) m_clear = 1;
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("ram_en", 32'(ram_en), 32'(e_en));
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_rst", 32'(ram_rst), 32'(e_rst));
      chk("clr_busy", 32'(clr_busy), 32'(e_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      if (e_en) begin
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_di", 32'(ram_di), 32'(e_di));
      end
      if (e_rsp != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(e_data));
    end
  end

  // Driver-side snapshot of the cycle just completed.
  logic [NR-1:0] s_ready, s_rsp;
  logic          s_busy;
  logic [DW-1:0] s_rdata;
  logic [AW-1:0] s_addr;

  task automatic tick();
    @(negedge clk);
    s_ready = req_ready; s_rsp = rsp_valid; s_busy = clr_busy;
    s_rdata = rsp_rdata; s_addr = ram_addr;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int id, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp);
    bit got = 1'b0;
    req_valid[id] = 1'b1; req_we[id] = we; a_addr[id] = addr; a_data[id] = d;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = s_ready[id];
    end
    req_valid[id] = 1'b0;
    chk("access_grant", 32'(got), 32'd1);
    if (!we && got) begin
      tick();
      chk("access_rsp_valid", 32'(s_rsp), 32'(NR'(1) << id));
      chk("access_rsp_rdata", 32'(s_rdata), 32'(exp));
    end
  endtask

  task automatic count_clear(input int already, output int n, output int bad);
    n = already; bad = 0;
    for (int k = 0; k < 1100; k++) begin
      tick();
      if (s_busy) begin
        n++;
        if (s_ready != '0) bad++;
      end else break;
    end
  endtask

  initial begin : stim
    int n, bad;
    // Reset, then power-on clear of the full RAM.
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    count_clear(0, n, bad);
    chk("init_clear_len", 32'(n), 32'd1024);
    access(2, 1'b0, 10'd5, 16'h0000, 16'h0000);

    // Write then read back through requester 0; requester 3 reads too.
    access(0, 1'b1, 10'h010, 16'hBEEF, 16'h0000);
    access(0, 1'b0, 10'h010, 16'h0000, 16'hBEEF);
    access(3, 1'b0, 10'h010, 16'h0000, 16'hBEEF);

    // All requesters reading continuously: rotation 0,1,2,3 with no bubbles.
    req_we = '0;
    for (int i = 0; i < NR; i++) a_addr[i] = AW'(16 + i);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("rr_grant", 32'(s_ready), 32'(4'b0001 << (k % 4)));
      if (k > 0) chk("rr_rsp", 32'(s_rsp), 32'(4'b0001 << ((k - 1) % 4)));
    end
    req_valid = '0;
    tick();
    chk("rr_rsp_tail", 32'(s_rsp), 32'h8);

    // Pointer at 2 with only 0 and 3 requesting: 3 wins, then 0.
    access(1, 1'b0, 10'h010, 16'h0000, 16'hBEEF);
    req_valid = 4'b1001;
    tick();
    chk("skip_first", 32'(s_ready), 32'h8);
    req_valid[3] = 1'b0;
    tick();
    chk("skip_second", 32'(s_ready), 32'h1);
    req_valid[0] = 1'b0;
    tick();

    // Clear requested in the same cycle as a read grant.
    req_valid[1] = 1'b1; a_addr[1] = 10'h010; clr_req = 1'b1;
    tick();
    chk("clr_grant", 32'(s_ready), 32'h2);
    req_valid = '1; clr_req = 1'b0;
    tick();
    chk("clr_rsp_valid", 32'(s_rsp), 32'h2);
    chk("clr_rsp_rdata", 32'(s_rdata), 32'hBEEF);
    chk("clr_busy_first", 32'(s_busy), 32'd1);
    count_clear(1, n, bad);
    chk("clr2_len", 32'(n), 32'd1024);
    chk("clr2_ready_low", 32'(bad), 32'd0);
    req_valid = '0;
    tick();
    access(2, 1'b0, 10'h010, 16'h0000, 16'h0000);

    // Reset asserted mid-clear at count 300, clear restarts from address 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (300) tick();
    chk("clr_at_300", 32'(ram_addr), 32'd300);
    rst_n = 1'b0;
    #1;
    chk("async_ram_en", 32'(ram_en), 32'd0);
    chk("async_ram_we", 32'(ram_we), 32'd0);
    chk("async_clr_busy", 32'(clr_busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("restart_addr", 32'(s_addr), 32'd0);
    chk("restart_busy", 32'(s_busy), 32'd1);
    count_clear(1, n, bad);
    chk("restart_len", 32'(n), 32'd1024);

    // Randomized traffic honouring the hold-while-not-ready rule.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!(req_valid[i] && !s_ready[i])) begin
          req_valid[i] = ($urandom_range(0, 99) < 55);
          req_we[i]    = ($urandom_range(0, 2) == 0);
          a_addr[i]    = AW'($urandom_range(0, 15));
          a_data[i]    = DW'($urandom);
        end
      end
      clr_req = ($urandom_range(0, 799) == 0);
      tick();
    end
    req_valid = '0; clr_req = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
